status_display: RTL and testbench

STATUS_DISPLAY -- requirements
Module: status_display

---
 rtl/status_display_if.sv | 20 ++
 rtl/status_display.sv | 164 ++++++++++++++++
 tb/tb_status_display.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/status_display_if.sv
// Status display bus: hood control inputs and display/buzzer outputs.
interface status_display_if;
   logic       power_on;
   logic       gesture_armed;
   logic [5:0] hand_time;
   logic [7:0] an;
   logic [7:0] seg;
   logic       beep;
   logic [5:0] remaining;

   modport master (
      output power_on, gesture_armed, hand_time,
      input  an, seg, beep, remaining
   );

   modport slave (
      input  power_on, gesture_armed, hand_time,
      output an, seg, beep, remaining
   );
endinterface

// File: rtl/status_display.sv
// Range-hood status display: gesture countdown, buzzer and 8-digit scan.
// Optional macro STATUS_DISPLAY_BLINK_EN blinks the last three seconds.
module status_display #(
   parameter int SEC_DIV  = 100_000_000,
   parameter int SCAN_DIV = 100_000
) (
   input logic             clk,
   input logic             reset,
   status_display_if.slave bus
);

   typedef enum logic [1:0] {OFF, IDLE, ARMED, EXPIRED} state_t;

   localparam int CW = $clog2(SEC_DIV + 1);
   localparam int SW = $clog2(SCAN_DIV + 1);

   localparam logic [3:0] C_P     = 4'd10;
   localparam logic [3:0] C_DASH  = 4'd11;
   localparam logic [3:0] C_BLANK = 4'd12;

   state_t          state, state_n;
   logic            gest_q;
   logic [5:0]      rem, rem_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [SW-1:0]   scan, scan_n;
   logic [2:0]      idx, idx_n;
   logic [7:0]      an_q, an_n;
   logic [7:0]      seg_q, seg_n;
   logic [3:0]      code;
   logic [7:0]      bcd;
   logic            blank;
   logic            rise, tick;

   function automatic logic [7:0] seg7(input logic [3:0] c);
      unique case (c)
         4'd0:    return 8'h3F;
         4'd1:    return 8'h06;
         4'd2:    return 8'h5B;
         4'd3:    return 8'h4F;
         4'd4:    return 8'h66;
         4'd5:    return 8'h6D;
         4'd6:    return 8'h7D;
         4'd7:    return 8'h07;
         4'd8:    return 8'h7F;
         4'd9:    return 8'h6F;
         C_P:     return 8'h73;
         C_DASH:  return 8'h40;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      logic [3:0] t;
      logic [5:0] u;
      t = 4'd0;
      u = v;
      for (int k = 0; k < 6; k++) begin
         if (u >= 6'd10) begin
            u = u - 6'd10;
            t = t + 4'd1;
         end
      end
      return {t, u[3:0]};
   endfunction

   assign rise = bus.gesture_armed & ~gest_q;
   assign tick = (cnt == CW'(SEC_DIV - 1));

   always_comb begin
      state_n = state;
      rem_n   = rem;
      cnt_n   = cnt;
      unique case (state)
         OFF: state_n = IDLE;
         IDLE, EXPIRED: begin
            if (rise) begin
               state_n = (bus.hand_time == 6'd0) ? EXPIRED : ARMED;
               rem_n   = bus.hand_time;
               cnt_n   = '0;
            end else if (state == EXPIRED) begin
               cnt_n = tick ? '0 : cnt + CW'(1);
               if (tick) state_n = IDLE;
            end
         end
         ARMED: begin
            if (!bus.gesture_armed) begin
               state_n = IDLE;
               rem_n   = 6'd0;
               cnt_n   = '0;
            end else if (tick) begin
               cnt_n = '0;
               rem_n = (rem <= 6'd1) ? 6'd0 : rem - 6'd1;
               if (rem <= 6'd1) state_n = EXPIRED;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
      endcase
      if (!bus.power_on) begin
         state_n = OFF;
         rem_n   = 6'd0;
         cnt_n   = '0;
      end
   end

   always_comb begin
      scan_n = '0;
      idx_n  = 3'd0;
      if (state != OFF) begin
         scan_n = (scan == SW'(SCAN_DIV - 1)) ? '0 : scan + SW'(1);
         idx_n  = (scan == SW'(SCAN_DIV - 1)) ? idx + 3'd1 : idx;
      end
   end

   // Outputs are built from next-state values so an/seg always agree.
   always_comb begin
      code  = C_BLANK;
      bcd   = to_bcd(rem_n);
      blank = 1'b0;
`ifdef STATUS_DISPLAY_BLINK_EN
      blank = (rem_n <= 6'd3) && (cnt_n >= CW'(SEC_DIV / 2));
`else
      blank = 1'b0;
`endif
      if (idx_n == 3'd7) begin
         code = C_P;
      end else if (state_n == ARMED) begin
         if (!blank && idx_n == 3'd1) code = bcd[7:4];
         if (!blank && idx_n == 3'd0) code = bcd[3:0];
      end else if (state_n == EXPIRED && idx_n <= 3'd1) begin
         code = C_DASH;
      end
      an_n  = (state_n == OFF) ? 8'h00 : 8'h01 << idx_n;
      seg_n = (state_n == OFF) ? 8'h00 : seg7(code);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= OFF;
         gest_q <= 1'b0;
         rem    <= 6'd0;
         cnt    <= '0;
         scan   <= '0;
         idx    <= 3'd0;
         an_q   <= 8'h00;
         seg_q  <= 8'h00;
      end else begin
         state  <= state_n;
         gest_q <= bus.gesture_armed;
         rem    <= rem_n;
         cnt    <= cnt_n;
         scan   <= scan_n;
         idx    <= idx_n;
         an_q   <= an_n;
         seg_q  <= seg_n;
      end
   end

   assign bus.an        = an_q;
   assign bus.seg       = seg_q;
   assign bus.beep      = (state == EXPIRED);
   assign bus.remaining = rem;

endmodule

// File: tb/tb_status_display.sv
// Directed bench for status_display with SEC_DIV=20, SCAN_DIV=2.
module tb_status_display;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   status_display_if bus ();

   status_display #(.SEC_DIV(20), .SCAN_DIV(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_an(input string tag, input logic [7:0] exp);
      int n = 0;
      while (bus.an !== exp && n < 40) begin
         step(1);
         n++;
      end
      check(tag, bus.an, exp);
   endtask

   logic [7:0] e_seg0;
   logic [7:0] e_seg1;
   int         n;
   int         beeps;

   initial begin
      reset             = 1'b1;
      bus.power_on      = 1'b0;
      bus.gesture_armed = 1'b0;
      bus.hand_time     = 6'd0;
      step(2);
      check("rst_an", bus.an, 8'h00);
      check("rst_seg", bus.seg, 8'h00);
      check("rst_beep", bus.beep, 1'b0);
      check("rst_rem", bus.remaining, 6'd0);

      // reset dominates power_on
      bus.power_on = 1'b1;
      step(1);
      check("rst_pwr_an", bus.an, 8'h00);

      // idle scan: each digit held two cycles, only digit 7 lit with P
      reset = 1'b0;
      step(1);
      for (int k = 0; k < 16; k++) begin
         check($sformatf("scan_an%0d", k), bus.an, 8'h01 << (k / 2));
         check($sformatf("scan_seg%0d", k), bus.seg,
               (k / 2 == 7) ? 8'h73 : 8'h00);
         step(1);
      end

      // full countdown from 5
      bus.hand_time     = 6'd5;
      bus.gesture_armed = 1'b1;
      step(1);
      check("arm_rem", bus.remaining, 6'd5);
      check("arm_beep", bus.beep, 1'b0);
      for (int s = 5; s >= 1; s--) begin
         step(19);
         check($sformatf("hold%0d", s), bus.remaining, s);
         step(1);
         check($sformatf("dec%0d", s), bus.remaining, s - 1);
      end
      check("exp_beep", bus.beep, 1'b1);
      n = 0;
      while (bus.beep && n < 40) begin
         if (bus.an == 8'h01) check("exp_seg0", bus.seg, 8'h40);
         if (bus.an == 8'h02) check("exp_seg1", bus.seg, 8'h40);
         n++;
         step(1);
      end
      check("beep_len", n, 20);
      check("idle_rem", bus.remaining, 6'd0);
      wait_an("idle_d0", 8'h01);
      check("idle_seg0", bus.seg, 8'h00);

      // two-digit value 35
      bus.gesture_armed = 1'b0;
      step(1);
      bus.hand_time     = 6'd35;
      bus.gesture_armed = 1'b1;
      step(1);
      check("r35_rem", bus.remaining, 6'd35);
      wait_an("r35_d1", 8'h02);
      check("r35_tens", bus.seg, 8'h4F);
      wait_an("r35_d0", 8'h01);
      check("r35_units", bus.seg, 8'h6D);
      bus.gesture_armed = 1'b0;
      step(1);
      check("cancel_rem", bus.remaining, 6'd0);
      check("cancel_beep", bus.beep, 1'b0);

      // remaining=3: blink on second half of each second when enabled
      for (int t = 0; t < 4; t++) begin
         bus.hand_time     = 6'd3;
         bus.gesture_armed = 1'b1;
         step(1);
         for (int j = 0; j < 20; j++) begin
`ifdef STATUS_DISPLAY_BLINK_EN
            e_seg0 = (j >= 10) ? 8'h00 : 8'h4F;
            e_seg1 = (j >= 10) ? 8'h00 : 8'h3F;
`else
            e_seg0 = 8'h4F;
            e_seg1 = 8'h3F;
`endif
            if (bus.an == 8'h01)
               check($sformatf("blink_d0_t%0d_j%0d", t, j), bus.seg, e_seg0);
            if (bus.an == 8'h02)
               check($sformatf("blink_d1_t%0d_j%0d", t, j), bus.seg, e_seg1);
            if (j < 19) step(1);
         end
         bus.gesture_armed = 1'b0;
         step(1);
         check($sformatf("blink_cancel%0d", t), bus.remaining, 6'd0);
      end

      // cancel coincident with the final tick: no beep ever
      bus.hand_time     = 6'd1;
      bus.gesture_armed = 1'b1;
      step(1);
      beeps = 0;
      for (int j = 0; j < 19; j++) begin
         beeps += bus.beep;
         step(1);
      end
      bus.gesture_armed = 1'b0;
      step(1);
      for (int j = 0; j < 5; j++) begin
         beeps += bus.beep;
         step(1);
      end
      check("last_cancel_rem", bus.remaining, 6'd0);
      check("last_cancel_beeps", beeps, 0);

      // zero hand_time expires immediately
      bus.hand_time     = 6'd0;
      bus.gesture_armed = 1'b1;
      step(1);
      check("zero_beep", bus.beep, 1'b1);
      check("zero_rem", bus.remaining, 6'd0);
      wait_an("zero_d0", 8'h01);
      check("zero_seg0", bus.seg, 8'h40);
      check("zero_beep0", bus.beep, 1'b1);
      wait_an("zero_d1", 8'h02);
      check("zero_seg1", bus.seg, 8'h40);
      check("zero_beep1", bus.beep, 1'b1);
      n = 0;
      while (bus.beep && n < 40) begin
         n++;
         step(1);
      end
      check("zero_end_beep", bus.beep, 1'b0);

      // power loss on the tick edge
      bus.gesture_armed = 1'b0;
      step(1);
      bus.hand_time     = 6'd5;
      bus.gesture_armed = 1'b1;
      step(1);
      step(19);
      bus.power_on = 1'b0;
      step(1);
      check("poff_an", bus.an, 8'h00);
      check("poff_seg", bus.seg, 8'h00);
      check("poff_beep", bus.beep, 1'b0);
      check("poff_rem", bus.remaining, 6'd0);
      bus.power_on = 1'b1;
      step(1);
      check("pon_an", bus.an, 8'h01);

      // reset mid-countdown
      bus.gesture_armed = 1'b0;
      step(1);
      bus.hand_time     = 6'd2;
      bus.gesture_armed = 1'b1;
      step(6);
      check("mid_rem", bus.remaining, 6'd2);
      reset = 1'b1;
      step(1);
      check("mid_rst_an", bus.an, 8'h00);
      check("mid_rst_seg", bus.seg, 8'h00);
      check("mid_rst_rem", bus.remaining, 6'd0);
      check("mid_rst_beep", bus.beep, 1'b0);
      reset = 1'b0;
      step(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
